gearbox_32_24: RTL and testbench

- Reverse of the 24->32 RGB gearbox: unpacks a stream of 32-bit RGBR words into 24-bit RGB pixels.
- Three input words carry four pixels. The block applies back-pressure to the source one cycle in four and emits at most one pixel per cycle.
- Sits after the 32-bit transport or storage path and feeds 24-bit pixel consumers.
- Frame ends come from data_in_last plus a valid-byte count on the final word.

---
 rtl/gearbox_32_24_pkg.sv | 36 +++
 rtl/gearbox_32_24.sv | 133 +++++++++++++
 tb/tb_gearbox_32_24.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_32_24_pkg.sv
// rtl/gearbox_32_24_pkg.sv - shared constants, phase encoding and byte helpers for the RGB gearboxes
package gearbox_32_24_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    // Legal (phase, bcnt) pairs for a last word, bit index {phase, bcnt}:
    // PH0/bcnt2, PH1/bcnt1, PH2/bcnt0, PH2/bcnt3.
    localparam logic [15:0] LAST_BCNT_LEGAL = 16'h0924;

    function automatic logic is_legal_last(phase_t ph, logic [1:0] bcnt);
        return LAST_BCNT_LEGAL[{ph, bcnt}];
    endfunction

    // Stream byte k of a word in transport order.
    function automatic logic [BYTE_W-1:0] stream_byte(logic [WORD_W-1:0] w, logic [1:0] k, logic msb_first);
        logic [1:0] pos;
        pos = msb_first ? (2'd3 - k) : k;
        return w[{pos, 3'b000} +: BYTE_W];
    endfunction

    // Build a pixel from three stream bytes, a being pixel byte 0.
    function automatic logic [PIX_W-1:0] pack_pixel(logic [BYTE_W-1:0] a, logic [BYTE_W-1:0] b,
                                                    logic [BYTE_W-1:0] c, logic msb_first);
        return msb_first ? {a, b, c} : {c, b, a};
    endfunction

endpackage

// File: rtl/gearbox_32_24.sv
// rtl/gearbox_32_24.sv - unpacks 32-bit RGBR words into 24-bit RGB pixels
module gearbox_32_24
    import gearbox_32_24_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_en,
    input  logic              data_in_last,
    input  logic [1:0]        data_in_bcnt,
    output logic              data_in_rdy,
    output logic [PIX_W-1:0]  data_out,
    output logic              data_out_en,
    output logic              data_out_last,
    output logic              frame_err
);

    phase_t             phase, phase_nx;
    logic [PIX_W-1:0]   res, res_nx;
    logic [1:0]         res_cnt, res_cnt_nx;
    logic               res_last, res_last_nx;

    logic [BYTE_W-1:0]  w0, w1, w2, w3;
    logic [BYTE_W-1:0]  r0, r1, r2;
    logic               accept;
    logic               legal;
    logic [2:0]         n_bytes;
    logic [3:0]         avail;

    logic               emit;
    logic [PIX_W-1:0]   pix_nx;
    logic               last_nx;
    logic               err_nx;

    assign w0 = stream_byte(data_in, 2'd0, MSB_FIRST);
    assign w1 = stream_byte(data_in, 2'd1, MSB_FIRST);
    assign w2 = stream_byte(data_in, 2'd2, MSB_FIRST);
    assign w3 = stream_byte(data_in, 2'd3, MSB_FIRST);

    // Residue bytes are kept oldest-first from the top of the register.
    assign r0 = res[23:16];
    assign r1 = res[15:8];
    assign r2 = res[7:0];

    assign data_in_rdy = (phase != PH3);
    assign accept      = data_en & data_in_rdy;
    assign n_bytes     = {1'b0, data_in_bcnt} + 3'd1;
    assign legal       = is_legal_last(phase, data_in_bcnt);
    // Bytes available for the pixel formed on this accept: residue plus the word's valid bytes.
    assign avail       = {2'b00, res_cnt} + (data_in_last ? {1'b0, n_bytes} : 4'd4);

    // Phase register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH0;
        end else begin
            phase <= phase_nx;
        end
    end

    // Next phase, pixel formation, residue update and frame-end decisions
    always_comb begin
        phase_nx    = phase;
        res_nx      = res;
        res_cnt_nx  = res_cnt;
        res_last_nx = res_last;
        emit        = 1'b0;
        pix_nx      = data_out;
        last_nx     = 1'b0;
        err_nx      = 1'b0;
        if (phase == PH3) begin
            emit        = 1'b1;
            pix_nx      = pack_pixel(r0, r1, r2, MSB_FIRST);
            last_nx     = res_last;
            res_last_nx = 1'b0;
            res_cnt_nx  = 2'd0;
            phase_nx    = PH0;
        end else if (accept) begin
            emit   = (avail >= 4'd3);
            err_nx = data_in_last & ~legal;
            if (phase == PH0) begin
                pix_nx = pack_pixel(w0, w1, w2, MSB_FIRST);
                res_nx = {w3, 16'h0000};
            end else if (phase == PH1) begin
                pix_nx = pack_pixel(r0, w0, w1, MSB_FIRST);
                res_nx = {w2, w3, 8'h00};
            end else begin
                pix_nx = pack_pixel(r0, r1, w0, MSB_FIRST);
                res_nx = {w1, w2, w3};
            end
            if (!data_in_last) begin
                phase_nx   = phase_t'(phase + 2'd1);
                res_cnt_nx = res_cnt + 2'd1;
            end else if (phase == PH2 && n_bytes == 3'd4) begin
                // Full group ends the frame: P3 still to come and carries last.
                phase_nx    = PH3;
                res_cnt_nx  = 2'd3;
                res_last_nx = 1'b1;
            end else begin
                // Frame ends here; leftover partial bytes are dropped.
                phase_nx   = PH0;
                res_cnt_nx = 2'd0;
                last_nx    = emit;
            end
        end
    end

    // Residue and registered pixel outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res           <= '0;
            res_cnt       <= 2'd0;
            res_last      <= 1'b0;
            data_out      <= '0;
            data_out_en   <= 1'b0;
            data_out_last <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            res           <= res_nx;
            res_cnt       <= res_cnt_nx;
            res_last      <= res_last_nx;
            data_out_en   <= emit;
            data_out_last <= last_nx;
            frame_err     <= err_nx;
            if (emit) begin
                data_out <= pix_nx;
            end
        end
    end

endmodule

// File: tb/tb_gearbox_32_24.sv
// tb/tb_gearbox_32_24.sv - self-checking bench for gearbox_32_24 against a byte-queue model
module tb_gearbox_32_24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        data_en;
    logic        data_in_last;
    logic [1:0]  data_in_bcnt;

    logic        rdy1, en1, last1, err1;
    logic [23:0] out1;
    logic        rdy0, en0, last0, err0;
    logic [23:0] out0;

    always #5 clk = ~clk;

    gearbox_32_24 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_en(data_en),
        .data_in_last(data_in_last), .data_in_bcnt(data_in_bcnt),
        .data_in_rdy(rdy1), .data_out(out1), .data_out_en(en1),
        .data_out_last(last1), .frame_err(err1)
    );

    gearbox_32_24 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_en(data_en),
        .data_in_last(data_in_last), .data_in_bcnt(data_in_bcnt),
        .data_in_rdy(rdy0), .data_out(out0), .data_out_en(en0),
        .data_out_last(last0), .frame_err(err0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the frame is a byte stream; every three bytes make a pixel,
    // one pixel per cycle; the block stalls while a full pixel is still queued.
    byte unsigned q1[$];
    byte unsigned q0[$];
    bit           fin;
    logic [23:0]  hold1, hold0;
    bit           exp_en, exp_last, exp_err;
    logic [23:0]  seen1[$];
    logic [23:0]  seen0[$];
    int           seen_err;
    int           seen_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit acc);
        int n;
        exp_en   = 1'b0;
        exp_last = 1'b0;
        exp_err  = 1'b0;
        if (acc) begin
            n = data_in_last ? int'(data_in_bcnt) + 1 : 4;
            for (int k = 0; k < n; k++) begin
                q1.push_back(data_in[31-8*k -: 8]);
                q0.push_back(data_in[8*k +: 8]);
            end
            if (data_in_last) fin = 1'b1;
        end
        if (q1.size() >= 3) begin
            exp_en = 1'b1;
            hold1  = {q1[0], q1[1], q1[2]};
            hold0  = {q0[2], q0[1], q0[0]};
            repeat (3) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
        end
        if (fin && q1.size() < 3) begin
            exp_last = exp_en;
            exp_err  = (q1.size() != 0);
            q1.delete();
            q0.delete();
            fin = 1'b0;
        end
    endtask

    task automatic tick(output bit acc);
        bit exp_rdy;
        exp_rdy = (q1.size() < 3);
        chk("rdy_msb", 32'(rdy1), 32'(exp_rdy));
        chk("rdy_lsb", 32'(rdy0), 32'(exp_rdy));
        acc = data_en && exp_rdy;
        model_edge(acc);
        @(posedge clk);
        #1;
        chk("en_msb",   32'(en1),   32'(exp_en));
        chk("last_msb", 32'(last1), 32'(exp_last));
        chk("err_msb",  32'(err1),  32'(exp_err));
        chk("pix_msb",  32'(out1),  32'(hold1));
        chk("en_lsb",   32'(en0),   32'(exp_en));
        chk("last_lsb", 32'(last0), 32'(exp_last));
        chk("err_lsb",  32'(err0),  32'(exp_err));
        chk("pix_lsb",  32'(out0),  32'(hold0));
        if (en1) seen1.push_back(out1);
        if (en0) seen0.push_back(out0);
        if (err1) seen_err++;
        if (last1) seen_last++;
    endtask

    task automatic send(input logic [31:0] w, input bit last, input logic [1:0] bcnt);
        bit acc;
        data_in      = w;
        data_en      = 1'b1;
        data_in_last = last;
        data_in_bcnt = bcnt;
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) tick(acc);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        data_en      = 1'b0;
        data_in_last = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic clear_log();
        seen1.delete();
        seen0.delete();
        seen_err  = 0;
        seen_last = 0;
    endtask

    function automatic logic [23:0] at1(input int i);
        return (i < seen1.size()) ? seen1[i] : 24'hxxxxxx;
    endfunction

    initial begin
        reset        = 1'b0;
        data_in      = '0;
        data_en      = 1'b0;
        data_in_last = 1'b0;
        data_in_bcnt = 2'd0;
        fin          = 1'b0;
        hold1        = '0;
        hold0        = '0;
        clear_log();

        // Reset state
        #3;
        chk("rst_rdy",  32'(rdy1),  32'd1);
        chk("rst_out",  32'(out1),  32'd0);
        chk("rst_en",   32'(en1),   32'd0);
        chk("rst_last", 32'(last1), 32'd0);
        chk("rst_err",  32'(err1),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Continuous group
        clear_log();
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55667788, 1'b0, 2'd0);
        send(32'h99AABBCC, 1'b0, 2'd0);
        idle(2);
        chk("s1_cnt", 32'(seen1.size()), 32'd4);
        chk("s1_p0", 32'(at1(0)), 32'h112233);
        chk("s1_p1", 32'(at1(1)), 32'h445566);
        chk("s1_p2", 32'(at1(2)), 32'h778899);
        chk("s1_p3", 32'(at1(3)), 32'hAABBCC);

        // Two-pixel frame
        clear_log();
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55660000, 1'b1, 2'd1);
        idle(2);
        chk("s2_cnt",  32'(seen1.size()), 32'd2);
        chk("s2_p1",   32'(at1(1)), 32'h445566);
        chk("s2_last", 32'(seen_last), 32'd1);
        chk("s2_err",  32'(seen_err), 32'd0);

        // Four-pixel frame, next word follows straight after the stall
        clear_log();
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55667788, 1'b0, 2'd0);
        send(32'h99AABBCC, 1'b1, 2'd3);
        send(32'h0A0B0C0D, 1'b1, 2'd2);
        idle(2);
        chk("s3_cnt",  32'(seen1.size()), 32'd5);
        chk("s3_p3",   32'(at1(3)), 32'hAABBCC);
        chk("s3_p4",   32'(at1(4)), 32'h0A0B0C);
        chk("s3_last", 32'(seen_last), 32'd2);

        // Intermittent input, data_en held high through the stall cycle
        clear_log();
        send(32'h11223344, 1'b0, 2'd0);
        idle(1);
        send(32'h55667788, 1'b0, 2'd0);
        idle(1);
        send(32'h99AABBCC, 1'b0, 2'd0);
        send(32'h11223344, 1'b1, 2'd2);
        idle(2);
        chk("s4_cnt", 32'(seen1.size()), 32'd5);
        chk("s4_p2",  32'(at1(2)), 32'h778899);
        chk("s4_p3",  32'(at1(3)), 32'hAABBCC);
        chk("s4_p4",  32'(at1(4)), 32'h112233);

        // Malformed last with no complete pixel
        clear_log();
        send(32'hDEADBEEF, 1'b1, 2'd1);
        idle(2);
        chk("s5_cnt", 32'(seen1.size()), 32'd0);
        chk("s5_err", 32'(seen_err), 32'd1);

        // Reset mid-group
        clear_log();
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55667788, 1'b0, 2'd0);
        data_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("s6_out", 32'(out1), 32'd0);
        chk("s6_en",  32'(en1),  32'd0);
        chk("s6_rdy", 32'(rdy1), 32'd1);
        q1.delete();
        q0.delete();
        fin   = 1'b0;
        hold1 = '0;
        hold0 = '0;
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        send(32'h01020304, 1'b1, 2'd2);
        idle(1);
        chk("s6_p0", 32'(at1(0)), 32'h010203);

        // LSB-first byte order
        clear_log();
        send(32'h44332211, 1'b1, 2'd2);
        idle(1);
        chk("s7_cnt", 32'(seen0.size()), 32'd1);
        if (seen0.size() > 0) chk("s7_p0", 32'(seen0[0]), 32'h332211);

        // Random frames with random gaps and random final byte counts
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                send($urandom, (i == len - 1), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
